// File: rtl/comparator_tracker.sv
// Tallies one-hot comparator results (GT/EQ/LT), flags illegal codes and
// tracks the length of the current run of identical legal results.
module comparator_tracker #(
  parameter int CNT_W     = 8,
  parameter int STREAK_TH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [0:2]       y,
  input  logic             clr,
  output logic [CNT_W-1:0] gt_cnt,
  output logic [CNT_W-1:0] eq_cnt,
  output logic [CNT_W-1:0] lt_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] streak_len,
  output logic             streak_hit,
  output logic             err_flag,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_GT   = 2'd1,
    S_EQ   = 2'd2,
    S_LT   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] MAX_V = '1;
  localparam logic [CNT_W-1:0] ONE_V = CNT_W'(1);
  localparam logic [CNT_W-1:0] TH_V  = CNT_W'(STREAK_TH);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] gt_q, gt_d, eq_q, eq_d, lt_q, lt_d, err_q, err_d;
  logic [CNT_W-1:0] streak_q, streak_d;
  logic             hit_q, hit_d;
  logic             flag_q, flag_d;

  logic             legal;
  state_t           cat;
  logic             same_run;
  logic [CNT_W-1:0] len_next;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == MAX_V) ? v : v + ONE_V;
  endfunction

  always_comb begin
    legal = 1'b1;
    cat   = S_IDLE;
    case (y)
      3'b100:  cat = S_GT;
      3'b010:  cat = S_EQ;
      3'b001:  cat = S_LT;
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    gt_d     = gt_q;
    eq_d     = eq_q;
    lt_d     = lt_q;
    err_d    = err_q;
    streak_d = streak_q;
    flag_d   = flag_q;
    hit_d    = 1'b0;
    same_run = (state_q == cat);
    len_next = same_run ? sat_inc(streak_q) : ONE_V;

    if (in_valid) begin
      if (legal) begin
        case (cat)
          S_GT:    gt_d = sat_inc(gt_q);
          S_EQ:    eq_d = sat_inc(eq_q);
          S_LT:    lt_d = sat_inc(lt_q);
          default: ;
        endcase
        state_d  = cat;
        streak_d = len_next;
        // A saturated run holding at STREAK_TH must not re-fire.
        hit_d    = (len_next == TH_V) && (!same_run || streak_q != TH_V);
      end else begin
        err_d    = sat_inc(err_q);
        flag_d   = 1'b1;
        state_d  = S_IDLE;
        streak_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      state_q  <= S_IDLE;
      gt_q     <= '0;
      eq_q     <= '0;
      lt_q     <= '0;
      err_q    <= '0;
      streak_q <= '0;
      hit_q    <= 1'b0;
      flag_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      gt_q     <= gt_d;
      eq_q     <= eq_d;
      lt_q     <= lt_d;
      err_q    <= err_d;
      streak_q <= streak_d;
      hit_q    <= hit_d;
      flag_q   <= flag_d;
    end
  end

  assign gt_cnt     = gt_q;
  assign eq_cnt     = eq_q;
  assign lt_cnt     = lt_q;
  assign err_cnt    = err_q;
  assign streak_len = streak_q;
  assign streak_hit = hit_q;
  assign err_flag   = flag_q;
  assign state      = state_q;

endmodule

// File: doc/comparator_tracker.md
COMPARATOR_TRACKER -- requirements
Module: comparator_tracker

Interface
REQ-001 SHALL provide parameter CNT_W, default 8: width of every counter and of streak_len.
REQ-002 SHALL provide parameter STREAK_TH, default 4: streak length that raises streak_hit; legal range 1 to 2^CNT_W-1.
REQ-003 SHALL provide clk  input  1: the single clock; all state updates on its rising edge.
REQ-004 SHALL provide rst  input  1: reset, synchronous and active-high.
REQ-005 SHALL provide in_valid  input  1: y carries a sample this cycle.
REQ-006 SHALL provide y  input  3, indexed [0:2], driven by the upstream comparator stage: y[0]=a[1]>a[0], y[1]=equal, y[2]=a[1]<a[0]. In a 3-bit literal, y[0] is the MSB, so 3'b100 means GT.
REQ-007 SHALL provide clr  input  1: synchronous soft clear.
REQ-008 SHALL provide gt_cnt, eq_cnt, lt_cnt  output  CNT_W each: count of accepted GT, EQ and LT samples.
REQ-009 SHALL provide err_cnt  output  CNT_W: count of accepted non-one-hot samples.
REQ-010 SHALL provide streak_len  output  CNT_W: length of the current run of identical legal results.
REQ-011 SHALL provide streak_hit  output  1: single-cycle pulse when a run reaches STREAK_TH.
REQ-012 SHALL provide err_flag  output  1: sticky flag, set by any illegal sample.
REQ-013 SHALL provide state  output  2: IDLE=0, GT=1, EQ=2, LT=3.

Function
REQ-014 A sample SHALL be accepted on a rising edge where in_valid=1, rst=0 and clr=0; all outputs SHALL be registered and reflect the sample one cycle after that edge.
REQ-015 Legal y codes SHALL be exactly 3'b100 (GT), 3'b010 (EQ) and 3'b001 (LT); every other code, including 3'b000 and 3'b111, SHALL be illegal.
REQ-016 On a legal accepted sample, the matching category counter SHALL increment by 1 and saturate at 2^CNT_W-1, with no wrap-around.
REQ-017 FSM with states IDLE, GT, EQ, LT: a legal sample SHALL move the FSM to the matching state from any state.
REQ-018 A legal sample whose category matches the current state SHALL set streak_len to streak_len+1, saturating at 2^CNT_W-1.
REQ-019 A legal sample whose category differs from the current state, or any legal sample taken from IDLE, SHALL set streak_len to 1.
REQ-020 On an illegal accepted sample:
- err_cnt SHALL increment, saturating;
- err_flag SHALL be set;
- the FSM SHALL go to IDLE and streak_len SHALL become 0;
- category counters SHALL be unchanged.
REQ-021 streak_hit SHALL be 1 for exactly one cycle when streak_len changes from STREAK_TH-1 to STREAK_TH; otherwise it SHALL be 0.
REQ-022 streak_hit SHALL NOT pulse again during a run that stays at or above STREAK_TH, including while streak_len is held at saturation.
REQ-023 With STREAK_TH=1, streak_hit SHALL pulse on the first sample of every new run.
REQ-024 When in_valid=0, every register SHALL hold its value, and streak_hit SHALL be 0.
REQ-025 err_flag SHALL clear only on rst or clr.

Reset
REQ-026 While rst=1 at an edge, the block SHALL set all counters, streak_len, streak_hit and err_flag to 0 and state to IDLE, regardless of in_valid and clr.
REQ-027 clr=1 at an edge SHALL have the same effect as rst, and any sample presented in the same cycle SHALL be dropped, not counted.
REQ-028 Priority SHALL be rst > clr > in_valid.
REQ-029 Reset or clear asserted in the middle of a run SHALL end that run, and the next legal sample SHALL start streak_len at 1.

Verification
REQ-030 rst=1 for 2 cycles with in_valid=1, y=3'b100 -> all outputs 0, state=IDLE.
REQ-031 STREAK_TH=4; four valid GT (3'b100) samples -> gt_cnt=4 and streak_len=1,2,3,4 on successive cycles; streak_hit=1 only in the cycle showing streak_len=4.
REQ-032 GT, GT, then EQ (3'b010) -> gt_cnt=2, eq_cnt=1, state=EQ, streak_len=1, streak_hit never asserted.
REQ-033 EQ, EQ, then 3'b110 -> err_cnt=1, err_flag=1, state=IDLE, streak_len=0, eq_cnt=2; a following LT (3'b001) gives streak_len=1, err_flag still 1.
REQ-034 CNT_W=8; 300 consecutive valid LT samples -> lt_cnt=255, streak_len=255, exactly one streak_hit pulse.
REQ-035 clr=1 with in_valid=1, y=3'b001 after prior activity -> all outputs 0, lt_cnt stays 0; in_valid=0 gaps mid-run leave streak_len unchanged.
